// File: rtl/alu_mdu.sv
// XLEN-wide integer ALU with RV32I base ops and an iterative radix-2 M-extension
// datapath; valid/ready on both operand and result sides.
module alu_mdu #(
  parameter int unsigned XLEN      = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = '1;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLL    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_SLT    = 5'b01000;
  localparam logic [4:0] OP_SLTU   = 5'b01001;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_REM    = 5'b10110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_d;
  logic            zero_d, out_valid_d, busy_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res, special_res, single_res;
  logic            is_mop, is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]     mul_sum, div_t;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, step_hi, step_lo, quo, rem;
  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]   fix_res;

  assign in_ready = (state_q == IDLE) && !flush;

  // Single-cycle base operations
  always_comb begin
    shamt = b[SHW-1:0];
    case (op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLL:  base_res = a << shamt;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = $signed(a) >>> shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      default: base_res = '0;
    endcase
  end

  // M-op decode, operand magnitudes and the divide special cases
  always_comb begin
    is_mop   = MULDIV_EN && (op[4:3] == 2'b10);
    is_div   = is_mop && op[2];
    sgn_a    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn_b    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = sgn_a && a[XLEN-1];
    b_neg    = sgn_b && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == ONES);
    special  = is_div && (div_zero || div_ovf);
    if (div_zero) special_res = op[1] ? a : ONES;
    else          special_res = op[1] ? '0 : a;
    single_res = is_mop ? special_res : base_res;
  end

  // Shared shift datapath: shift-add multiply or restoring divide, plus sign fix-up
  always_comb begin
    mul_sum  = {1'b0, hi_q} + ({1'b0, m_q} & {(XLEN+1){lo_q[0]}});
    div_t    = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_t >= {1'b0, m_q};
    div_diff = div_t[XLEN-1:0] - m_q;
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff : div_t[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_raw = {step_hi, step_lo};
    prod     = neg_q ? -prod_raw : prod_raw;
    quo      = neg_q ? -step_lo : step_lo;
    rem      = neg_q ? -step_hi : step_hi;
    case (op_q)
      3'b000:                fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fix_res = quo;
      default:               fix_res = rem;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    result_d    = result;
    zero_d      = zero;
    out_valid_d = out_valid;
    busy_d      = busy;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      zero_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_mop && !special) begin
              state_d = BUSY;
              busy_d  = 1'b1;
              cnt_d   = CW'(XLEN);
              op_d    = op[2:0];
              neg_d   = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
              hi_d    = '0;
              lo_d    = is_div ? a_mag : b_mag;
              m_d     = is_div ? b_mag : a_mag;
            end else begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              result_d    = single_res;
              zero_d      = (single_res == '0);
            end
          end
        end
        BUSY: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            result_d    = fix_res;
            zero_d      = (fix_res == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            zero_d      = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      result    <= result_d;
      zero      <= zero_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [4:0]  op;
  logic [31:0] a, b, result;

  logic rand_ready = 1'b0, rand_bit = 1'b1, forced_ready = 1'b1;
  assign out_ready = rand_ready ? rand_bit : forced_ready;

  alu_mdu #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; int acc; int lat; } exp_t;
  exp_t q[$];
  int   cyc = 0, n_checks = 0, n_fail = 0, bcnt = 0;
  bit   ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rand_bit <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx, sy;
    longint      lx, ly, uy, p;
    logic [63:0] pu;
    bit          ovf;
    sx  = x;  sy = y;
    lx  = sx; ly = sy;
    uy  = longint'({32'h0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  return 32'(sx >>> y[4:0]);
      5'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd16: begin p = lx * ly; return 32'(p); end
      5'd17: begin p = lx * ly; return 32'(p >>> 32); end
      5'd18: begin p = lx * uy; return 32'(p >>> 32); end
      5'd19: begin pu = {32'h0, x} * {32'h0, y}; return pu[63:32]; end
      5'd20: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
      5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd22: return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < 5'd16 || o > 5'd23) return 1;
    if (o >= 5'd20 && (y == 0 || ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Result monitor: latency on rising out_valid, value on handshake
  always @(negedge clk) begin
    if (!busy && !out_valid) bcnt = 0;
    else if (busy) bcnt++;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        if (!ov_prev) chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        if (!ov_prev) begin
          chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          chk("busy_cycles", 32'(bcnt), 32'(q[0].lat - 1));
        end
        if (out_ready) begin
          chk("result", result, q[0].res);
          chk("zero", 32'(zero), 32'(q[0].res == 32'h0));
          void'(q.pop_front());
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] e, input int lat, input bit expect_out);
    int acc;
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready low for 200 cycles (op %0d)", o);
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    if (expect_out) q.push_back('{res: e, acc: acc, lat: lat});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  // Abort an in-flight DIVU at its 10th busy cycle with flush or rst
  task automatic abort_test(input bit use_rst);
    bit quiet;
    send(5'd21, 32'h00FF_FFFF, 32'h0000_0123, 32'h0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else begin
      flush = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd9; b = 32'd9;
    end
    @(negedge clk);
    chk("busy_at_abort", 32'(busy), 32'd1);
    if (!use_rst) chk("in_ready_during_flush", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_abort", 32'(in_ready), 32'd1);
    chk("busy_after_abort", 32'(busy), 32'd0);
    chk("out_valid_after_abort", 32'(out_valid), 32'd0);
    chk("result_after_abort", result, use_rst ? 32'h0 : 32'd7);
    quiet = 1'b1;
    repeat (40) begin @(negedge clk); if (out_valid) quiet = 1'b0; end
    chk("no_output_after_abort", 32'(quiet), 32'd1);
    send(5'd0, 32'd1, 32'd1, 32'd2, 1, 1'b1);
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  o;
    logic [31:0] x, y;
    int          r;
    bit          held;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    send(5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE, 1,  1'b1);
    send(5'd1,  32'd7,          32'd7,          32'h0,         1,  1'b1);
    send(5'd17, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF, 33, 1'b1);
    send(5'd19, 32'h8000_0000,  32'd2,          32'h1,         33, 1'b1);
    send(5'd16, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1,         33, 1'b1);
    send(5'd20, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33, 1'b1);
    send(5'd22, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33, 1'b1);
    send(5'd21, 32'h1234,       32'd0,          32'hFFFF_FFFF, 1,  1'b1);
    send(5'd23, 32'h1234,       32'd0,          32'h1234,      1,  1'b1);
    send(5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  1'b1);
    send(5'd22, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         1,  1'b1);
    send(5'd13, 32'h1234,       32'h5678,       32'h0,         1,  1'b1);
    drain();

    // Backpressure: result held while out_ready is low
    forced_ready = 1'b0;
    send(5'd0, 32'd3, 32'd4, 32'd7, 1, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    held = 1'b1;
    repeat (5) begin
      if (!out_valid || result !== 32'd7 || in_ready) held = 1'b0;
      @(negedge clk);
    end
    chk("bp_held_stable", 32'(held), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 forced_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    abort_test(1'b0);
    abort_test(1'b1);

    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      if (r < 10)       o = 5'(r);
      else if (r < 18)  o = 5'(16 + r - 10);
      else if (r == 18) o = 5'(10 + $urandom_range(0, 5));
      else              o = 5'(24 + $urandom_range(0, 7));
      x = rnd_opnd();
      y = rnd_opnd();
      send(o, x, y, ref_model(o, x, y), lat_of(o, x, y), 1'b1);
    end
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
